mem_access_stage: RTL and testbench

- MEM pipeline stage; consumes the EX/MEM register outputs (address, store data, memory control bits) and drives the data-memory request/grant/response bus.
- Performs byte-lane steering and byte enables for stores, and extraction plus sign/zero extension for loads.
- Raises stall_req to the stall controller until the access completes, then presents the result to the MEM/WB register.

---
 rtl/mem_access_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/gnt/rsp bus, steers store lanes and extends loads.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
`timescale 1ns/1ps

module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic [ADDR_WIDTH-1:0] alu_res_mem,
    input  logic [DATA_WIDTH-1:0] bypass_op2_mem,
    input  logic                  mem_read_mem,
    input  logic                  mem_write_mem,
    input  logic [1:0]            mask_mem,
    input  logic                  unsigned_load_mem,
    input  logic                  reg_write_mem,
    input  logic                  mem_to_reg_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  stall_req,
    output logic [DATA_WIDTH-1:0] load_data_wb,
    output logic [ADDR_WIDTH-1:0] alu_res_wb,
    output logic                  reg_write_wb,
    output logic                  mem_to_reg_wb,
    output logic                  misalign_exc
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_GNT = 2'b01,
        WAIT_RSP = 2'b10,
        DONE     = 2'b11
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   load_data_r;
    logic [DATA_WIDTH-1:0]   load_ext_s;
    logic                    access_s;
    logic                    is_store_s;
    logic                    trap_s;
    logic [3:0]              be_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic                    unused_stall_s;

    // Size 2'b11 falls into the word arm everywhere below.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] steer_store(input logic [1:0] size, input logic [31:0] op2);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{op2[7:0]}};
            2'b01:   wd = {2{op2[15:0]}};
            default: wd = op2;
        endcase
        return wd;
    endfunction

    // Half-word extraction only looks at addr[1], so an odd half address is force-aligned.
    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic [1:0] off,
                                                input logic uns, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] ext;
        case (size)
            2'b00:   sh = rdata >> {off, 3'b000};
            2'b01:   sh = rdata >> {off[1], 4'b0000};
            default: sh = rdata;
        endcase
        case (size)
            2'b00:   ext = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ext = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: ext = sh;
        endcase
        return ext;
    endfunction

    assign access_s   = mem_read_mem | mem_write_mem;
    assign is_store_s = mem_write_mem;
    assign be_s       = byte_enables(mask_mem, alu_res_mem[1:0]);
    assign wdata_s    = steer_store(mask_mem, bypass_op2_mem);
    assign load_ext_s = extend_load(mask_mem, alu_res_mem[1:0], unsigned_load_mem, dmem_rdata);

`ifdef MISALIGN_TRAP_EN
    logic misaligned_s;
    assign misaligned_s = ((mask_mem == 2'b01) & alu_res_mem[0]) |
                          (mask_mem[1] & (alu_res_mem[1:0] != 2'b00));
    assign trap_s       = (state_r == IDLE) & access_s & misaligned_s;
`else
    assign trap_s       = 1'b0;
`endif

    // Only the MEM hold bit matters here; the rest of the stall vector belongs to other stages.
    assign unused_stall_s = ^{stall[5], stall[3:0]};

    // Request fields are only driven while a request is on the bus.
    assign dmem_we    = dmem_req & is_store_s;
    assign dmem_addr  = dmem_req ? {alu_res_mem[ADDR_WIDTH-1:2], 2'b00} : {ADDR_WIDTH{1'b0}};
    assign dmem_be    = dmem_req ? be_s : 4'b0000;
    assign dmem_wdata = dmem_req ? wdata_s : {DATA_WIDTH{1'b0}};

    assign alu_res_wb    = alu_res_mem;
    assign mem_to_reg_wb = mem_to_reg_mem;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Load result capture; only a response while waiting for one is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_data_r <= {DATA_WIDTH{1'b0}};
        end else if ((state_r == WAIT_RSP) && dmem_rvalid) begin
            load_data_r <= load_ext_s;
        end else begin
            load_data_r <= load_data_r;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt_s  = state_r;
        dmem_req     = 1'b0;
        stall_req    = 1'b0;
        load_data_wb = {DATA_WIDTH{1'b0}};
        misalign_exc = 1'b0;
        reg_write_wb = reg_write_mem;
        case (state_r)
            IDLE: begin
                if (trap_s) begin
                    misalign_exc = 1'b1;
                    reg_write_wb = 1'b0;
                end else if (access_s) begin
                    dmem_req  = 1'b1;
                    stall_req = 1'b1;
                    if (dmem_gnt) begin
                        state_nxt_s = is_store_s ? DONE : WAIT_RSP;
                    end else begin
                        state_nxt_s = WAIT_GNT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_GNT: begin
                dmem_req  = 1'b1;
                stall_req = 1'b1;
                if (dmem_gnt) begin
                    state_nxt_s = is_store_s ? DONE : WAIT_RSP;
                end else begin
                    state_nxt_s = WAIT_GNT;
                end
            end
            WAIT_RSP: begin
                stall_req = 1'b1;
                if (dmem_rvalid) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            DONE: begin
                load_data_wb = load_data_r;
                if (stall[4]) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: reactive memory model plus a scoreboard of expected load results.
`timescale 1ns/1ps

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [31:0] alu_res_mem;
    logic [31:0] bypass_op2_mem;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [1:0]  mask_mem;
    logic        unsigned_load_mem;
    logic        reg_write_mem;
    logic        mem_to_reg_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_req;
    logic [31:0] load_data_wb;
    logic [31:0] alu_res_wb;
    logic        reg_write_wb;
    logic        mem_to_reg_wb;
    logic        misalign_exc;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .alu_res_mem(alu_res_mem), .bypass_op2_mem(bypass_op2_mem),
        .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
        .mask_mem(mask_mem), .unsigned_load_mem(unsigned_load_mem),
        .reg_write_mem(reg_write_mem), .mem_to_reg_mem(mem_to_reg_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_req(stall_req), .load_data_wb(load_data_wb),
        .alu_res_wb(alu_res_wb), .reg_write_wb(reg_write_wb),
        .mem_to_reg_wb(mem_to_reg_wb), .misalign_exc(misalign_exc)
    );

    // Reference models, written as explicit lane tables.
    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'b00) begin
            case (off)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end else if (sz == 2'b01) begin
            return off[1] ? 4'b1100 : 4'b0011;
        end else begin
            return 4'b1111;
        end
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] op2);
        if (sz == 2'b00)      return {op2[7:0], op2[7:0], op2[7:0], op2[7:0]};
        else if (sz == 2'b01) return {op2[15:0], op2[15:0]};
        else                  return op2;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [1:0] off,
                                               input logic uns, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        if (sz == 2'b00)      return uns ? {24'd0, b} : {{24{b[7]}}, b};
        else if (sz == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
        else                  return rd;
    endfunction

    // Drives one access from posedge+1 and acts as memory; returns what was observed.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] msk, input logic uns,
                             input logic [31:0] addr, input logic [31:0] op2, input logic [31:0] rdata,
                             input int gnt_dly, input int rsp_dly, input int hold,
                             output int req_cyc, output int stall_cyc, output logic chg,
                             output logic we_o, output logic [3:0] be_o, output logic [31:0] addr_o,
                             output logic [31:0] wd_o, output logic [31:0] ld_o,
                             output logic [31:0] idle_ld, output logic done_o, output logic hold_ok);
        int req_seen;
        int since;
        logic first;
        req_seen = 0; since = -1; first = 1'b1;
        req_cyc = 0; stall_cyc = 0; chg = 1'b0; done_o = 1'b0; hold_ok = 1'b1;
        we_o = 1'b0; be_o = 4'h0; addr_o = 32'h0; wd_o = 32'h0; ld_o = 32'h0; idle_ld = 32'h0;
        mem_read_mem = rd; mem_write_mem = wr; mask_mem = msk; unsigned_load_mem = uns;
        alu_res_mem = addr; bypass_op2_mem = op2; reg_write_mem = rd; mem_to_reg_mem = rd;
        stall = 6'b000000;
        for (int c = 0; c < 40 && !done_o; c++) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
            #1;
            if (dmem_req && (req_seen == gnt_dly)) dmem_gnt = 1'b1;
            if (rd && !wr && (since > 0) && (since == rsp_dly)) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdata;
            end
            @(negedge clk);
            if (dmem_req) begin
                req_cyc++;
                if (first) begin
                    we_o = dmem_we; be_o = dmem_be; addr_o = dmem_addr; wd_o = dmem_wdata;
                    first = 1'b0;
                end else if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {we_o, be_o, addr_o, wd_o}) begin
                    chg = 1'b1;
                end
            end
            if (stall_req) stall_cyc++;
            else begin
                done_o = 1'b1;
                ld_o   = load_data_wb;
            end
            if (dmem_gnt) since = 1;
            else if (since > 0) since++;
            if (dmem_req && !dmem_gnt) req_seen++;
            if (!done_o) begin
                @(posedge clk);
                #1;
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (done_o && hold > 0) begin
            stall = 6'b010000;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                if (h == hold - 1) stall = 6'b000000;
                @(negedge clk);
                if (load_data_wb !== ld_o || dmem_req !== 1'b0 || stall_req !== 1'b0) hold_ok = 1'b0;
            end
        end
        mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        @(posedge clk);
        #1;
        idle_ld = load_data_wb;
    endtask

    int          rq, st;
    logic        chg, we, dn, hok;
    logic [3:0]  be;
    logic [31:0] ad, wd, ld, ild, exp;

    task automatic test_reset();
        rst = 1'b0; stall = 6'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0; mask_mem = 2'b00;
        unsigned_load_mem = 1'b0; bypass_op2_mem = 32'h0; alu_res_mem = 32'hDEAD_BEE0;
        reg_write_mem = 1'b1; mem_to_reg_mem = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({dmem_req, stall_req, misalign_exc, dmem_we, dmem_be} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000000", {dmem_req, stall_req, misalign_exc, dmem_we, dmem_be});
        end
        n_checks++;
        if ({load_data_wb, dmem_addr, dmem_wdata} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", load_data_wb, dmem_addr, dmem_wdata);
        end
        n_checks++;
        if ({alu_res_wb, reg_write_wb, mem_to_reg_wb} !== {32'hDEAD_BEE0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL reset_passthru: got %h %b %b want deadbee0 1 1", alu_res_wb, reg_write_wb, mem_to_reg_wb);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_byte();
        do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1, 0,
                  rq, st, chg, we, be, ad, wd, ld, ild, dn, hok);
        n_checks++;
        if (dn !== 1'b1) begin n_fail++; $display("FAIL sb_timeout: got done=%b want 1", dn); end
        n_checks++;
        if ({we, be, ad, wd} !== {1'b1, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5}) begin
            n_fail++; $display("FAIL sb_fields: got we=%b be=%b addr=%h wd=%h want 1 1000 00001000 a5a5a5a5", we, be, ad, wd);
        end
        n_checks++;
        if (rq !== 1 || st !== 1) begin n_fail++; $display("FAIL sb_latency: got req=%0d stall=%0d want 1 1", rq, st); end
        n_checks++;
        if (ild !== 32'h0) begin n_fail++; $display("FAIL sb_idle: got %h want 0", ild); end
    endtask

    task automatic test_load_half();
        for (int u = 0; u < 2; u++) begin
            exp_q.push_back(model_load(2'b01, 2'b10, u[0], 32'h8001_1234));
            do_access(1'b1, 1'b0, 2'b01, u[0], 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1, 0,
                      rq, st, chg, we, be, ad, wd, ld, ild, dn, hok);
            exp = exp_q.pop_front();
            n_checks++;
            if (dn !== 1'b1 || ld !== exp) begin
                n_fail++; $display("FAIL lh_data uns=%0d: got %h done=%b want %h", u, ld, dn, exp);
            end
            n_checks++;
            if ({we, be, ad} !== {1'b0, 4'b1100, 32'h0000_2000} || rq !== 1 || st !== 2) begin
                n_fail++; $display("FAIL lh_bus uns=%0d: got we=%b be=%b addr=%h req=%0d stall=%0d want 0 1100 00002000 1 2", u, we, be, ad, rq, st);
            end
            n_checks++;
            if (ild !== 32'h0) begin n_fail++; $display("FAIL lh_idle: got %h want 0", ild); end
        end
    endtask

    task automatic test_load_word_delay();
        exp_q.push_back(model_load(2'b10, 2'b00, 1'b0, 32'hCAFE_F00D));
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 3, 2, 0,
                  rq, st, chg, we, be, ad, wd, ld, ild, dn, hok);
        exp = exp_q.pop_front();
        n_checks++;
        if (dn !== 1'b1 || ld !== exp) begin n_fail++; $display("FAIL lw_data: got %h done=%b want %h", ld, dn, exp); end
        n_checks++;
        if (rq !== 4 || st !== 6) begin n_fail++; $display("FAIL lw_latency: got req=%0d stall=%0d want 4 6", rq, st); end
        n_checks++;
        if (chg !== 1'b0 || be !== 4'b1111) begin n_fail++; $display("FAIL lw_stable: got chg=%b be=%b want 0 1111", chg, be); end
    endtask

    task automatic test_done_hold();
        exp_q.push_back(model_load(2'b00, 2'b01, 1'b0, 32'h1234_8056));
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_5001, 32'h0, 32'h1234_8056, 0, 1, 2,
                  rq, st, chg, we, be, ad, wd, ld, ild, dn, hok);
        exp = exp_q.pop_front();
        n_checks++;
        if (dn !== 1'b1 || ld !== exp) begin n_fail++; $display("FAIL hold_data: got %h done=%b want %h", ld, dn, exp); end
        n_checks++;
        if (hok !== 1'b1 || rq !== 1) begin n_fail++; $display("FAIL hold_state: got ok=%b req=%0d want 1 1", hok, rq); end
        n_checks++;
        if (ild !== 32'h0) begin n_fail++; $display("FAIL hold_idle: got %h want 0", ild); end
    endtask

    task automatic test_reset_mid();
        mem_read_mem = 1'b1; mem_write_mem = 1'b0; mask_mem = 2'b10; alu_res_mem = 32'h0000_6000;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        dmem_gnt = dmem_req;
        @(negedge clk);
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        n_checks++;
        if ({dmem_req, stall_req} !== 2'b01) begin n_fail++; $display("FAIL rm_waitrsp: got req,stall=%b want 01", {dmem_req, stall_req}); end
        rst = 1'b0; mem_read_mem = 1'b0;
        #1;
        n_checks++;
        if ({dmem_req, stall_req} !== 2'b00) begin n_fail++; $display("FAIL rm_inreset: got req,stall=%b want 00", {dmem_req, stall_req}); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({load_data_wb, stall_req, dmem_req} !== 34'h0) begin
            n_fail++; $display("FAIL rm_late_rvalid: got ld=%h stall=%b req=%b want 0 0 0", load_data_wb, stall_req, dmem_req);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        mem_read_mem = 1'b1; mem_write_mem = 1'b0; mask_mem = 2'b10; alu_res_mem = 32'h0000_3002;
        reg_write_mem = 1'b1; dmem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({misalign_exc, dmem_req, stall_req, reg_write_wb} !== 4'b1000) begin
                n_fail++; $display("FAIL ma_trap cyc%0d: got exc,req,stall,rw=%b want 1000", k, {misalign_exc, dmem_req, stall_req, reg_write_wb});
            end
            @(posedge clk);
            #1;
        end
        mem_read_mem = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({misalign_exc, reg_write_wb} !== 2'b01) begin
            n_fail++; $display("FAIL ma_clear: got exc,rw=%b want 01", {misalign_exc, reg_write_wb});
        end
        @(posedge clk);
        #1;
`else
        exp_q.push_back(model_load(2'b10, 2'b10, 1'b0, 32'h89AB_CDEF));
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 32'h89AB_CDEF, 0, 1, 0,
                  rq, st, chg, we, be, ad, wd, ld, ild, dn, hok);
        exp = exp_q.pop_front();
        n_checks++;
        if ({be, ad} !== {4'b1111, 32'h0000_3000} || dn !== 1'b1 || ld !== exp) begin
            n_fail++; $display("FAIL ma_word: got be=%b addr=%h ld=%h want 1111 00003000 %h", be, ad, ld, exp);
        end
        exp_q.push_back(model_load(2'b01, 2'b11, 1'b1, 32'h89AB_CDEF));
        do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2003, 32'h0, 32'h89AB_CDEF, 0, 1, 0,
                  rq, st, chg, we, be, ad, wd, ld, ild, dn, hok);
        exp = exp_q.pop_front();
        n_checks++;
        if (be !== 4'b1100 || dn !== 1'b1 || ld !== exp) begin
            n_fail++; $display("FAIL ma_half: got be=%b ld=%h want 1100 %h", be, ld, exp);
        end
        n_checks++;
        if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL ma_tied: got %b want 0", misalign_exc); end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            logic        r, w, u;
            logic [1:0]  sz;
            logic [31:0] a, op, rdat;
            int          gd, rsd, exp_st;
            r = 1'($urandom_range(1)); w = 1'($urandom_range(1));
            if (!r && !w) r = 1'b1;
            sz = 2'($urandom_range(3)); u = 1'($urandom_range(1));
            a = $urandom; op = $urandom; rdat = $urandom;
`ifdef MISALIGN_TRAP_EN
            if (sz == 2'b01) a[0] = 1'b0;
            else if (sz[1]) a[1:0] = 2'b00;
`endif
            gd = $urandom_range(2); rsd = $urandom_range(2, 1);
            if (r && !w) exp_q.push_back(model_load(sz, a[1:0], u, rdat));
            do_access(r, w, sz, u, a, op, rdat, gd, rsd, 0, rq, st, chg, we, be, ad, wd, ld, ild, dn, hok);
            exp_st = gd + 1 + ((r && !w) ? rsd : 0);
            n_checks++;
            if (dn !== 1'b1 || rq !== gd + 1 || st !== exp_st || chg !== 1'b0) begin
                n_fail++; $display("FAIL b2b_timing %0d: got done=%b req=%0d stall=%0d chg=%b want 1 %0d %0d 0", i, dn, rq, st, chg, gd + 1, exp_st);
            end
            n_checks++;
            if ({we, be, ad} !== {w, model_be(sz, a[1:0]), a[31:2], 2'b00}) begin
                n_fail++; $display("FAIL b2b_bus %0d: got we=%b be=%b addr=%h want %b %b %h", i, we, be, ad, w, model_be(sz, a[1:0]), {a[31:2], 2'b00});
            end
            if (w) begin
                n_checks++;
                if (wd !== model_wdata(sz, op)) begin
                    n_fail++; $display("FAIL b2b_wdata %0d: got %h want %h", i, wd, model_wdata(sz, op));
                end
            end else begin
                exp = exp_q.pop_front();
                n_checks++;
                if (ld !== exp) begin n_fail++; $display("FAIL b2b_load %0d: got %h want %h", i, ld, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_load_word_delay();
        test_done_hold();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
